div_unit: RTL and testbench

- Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions in the EX stage of the femtoRV32 pipeline.
- Sits directly downstream of the ALU-control decode and consumes its 5-bit ALU_sel code.
- Holds the pipeline via stall until the quotient or remainder is ready, then presents it for EX/MEM capture.
- The MUL family stays in the single-cycle ALU.

---
 rtl/alu_defs.sv | 33 +++
 rtl/div_unit.sv | 128 ++++++++++++
 tb/tb_div_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_defs.sv
// Shared ALU definitions for the femtoRV32 EX stage: operation codes, datapath width
// and the divider state encoding.
package alu_defs;

  localparam int ALU_XLEN = 32;

  localparam logic [4:0] ALU_ADD    = 5'b000_00;
  localparam logic [4:0] ALU_SUB    = 5'b000_01;
  localparam logic [4:0] ALU_PASS   = 5'b000_10;
  localparam logic [4:0] ALU_OR     = 5'b000_11;
  localparam logic [4:0] ALU_AND    = 5'b001_00;
  localparam logic [4:0] ALU_XOR    = 5'b001_01;
  localparam logic [4:0] ALU_SRL    = 5'b001_10;
  localparam logic [4:0] ALU_SRA    = 5'b001_11;
  localparam logic [4:0] ALU_SLL    = 5'b010_00;
  localparam logic [4:0] ALU_MUL    = 5'b010_01;
  localparam logic [4:0] ALU_MULH   = 5'b010_10;
  localparam logic [4:0] ALU_MULHSU = 5'b010_11;
  localparam logic [4:0] ALU_MULHU  = 5'b011_00;
  localparam logic [4:0] ALU_SLT    = 5'b011_01;
  localparam logic [4:0] ALU_DIV    = 5'b011_10;
  localparam logic [4:0] ALU_SLTU   = 5'b011_11;
  localparam logic [4:0] ALU_DIVU   = 5'b100_00;
  localparam logic [4:0] ALU_REM    = 5'b100_01;
  localparam logic [4:0] ALU_REMU   = 5'b100_10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU; stalls the pipeline while
// busy and presents the quotient or remainder with a one-cycle done pulse.
module div_unit
  import alu_defs::*;
#(
  parameter int XLEN  = ALU_XLEN,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [4:0]      ALU_sel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   rem_q, quo_q, dvs_q, result_q;
  logic              is_rem_q, neg_quo_q, neg_rem_q;
  logic              busy_q, done_q;

  logic              is_div_cls, is_signed, is_rem, accept;
  logic [XLEN-1:0]   abs_a, abs_b, min_neg;
  logic [XLEN:0]     trial;
  logic [XLEN-1:0]   rem_d, quo_d, quo_fix, rem_fix;

  always_comb begin
    is_div_cls = (ALU_sel == ALU_DIV) || (ALU_sel == ALU_DIVU) ||
                 (ALU_sel == ALU_REM) || (ALU_sel == ALU_REMU);
    is_signed  = (ALU_sel == ALU_DIV) || (ALU_sel == ALU_REM);
    is_rem     = (ALU_sel == ALU_REM) || (ALU_sel == ALU_REMU);
    min_neg    = {1'b1, {(XLEN-1){1'b0}}};
    abs_a      = (is_signed && op_a[XLEN-1]) ? -op_a : op_a;
    abs_b      = (is_signed && op_b[XLEN-1]) ? -op_b : op_b;

    // Partial remainder stays below the divisor, so a failed trial never needs bit XLEN.
    trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
    if (trial[XLEN]) begin
      rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
      quo_d = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      rem_d = trial[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b1};
    end
    quo_fix = neg_quo_q ? -quo_d : quo_d;
    rem_fix = neg_rem_q ? -rem_d : rem_d;
  end

  assign accept = (state_q == IDLE) && start && is_div_cls && !flush;
  assign stall  = rst_n && (accept || (state_q == CALC));
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (accept) begin
            is_rem_q  <= is_rem;
            neg_quo_q <= is_signed && (op_a[XLEN-1] ^ op_b[XLEN-1]);
            neg_rem_q <= is_signed && op_a[XLEN-1];
            quo_q     <= abs_a;
            dvs_q     <= abs_b;
            rem_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            if (op_b == '0) begin
              result_q <= is_rem ? op_a : '1;
              state_q  <= DONE;
              done_q   <= 1'b1;
            end else if (is_signed && (op_a == min_neg) && (op_b == '1)) begin
              result_q <= is_rem ? '0 : min_neg;
              state_q  <= DONE;
              done_q   <= 1'b1;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) begin
            result_q <= is_rem_q ? rem_fix : quo_fix;
            state_q  <= DONE;
            done_q   <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operations
// compared against a plain-arithmetic model of the RV32M divide rules.
module tb_div_unit;

  localparam logic [4:0] C_ADD  = 5'b000_00;
  localparam logic [4:0] C_DIV  = 5'b011_10;
  localparam logic [4:0] C_DIVU = 5'b100_00;
  localparam logic [4:0] C_REM  = 5'b100_01;
  localparam logic [4:0] C_REMU = 5'b100_10;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [4:0]  alu_sel;
  logic [31:0] op_a, op_b;
  logic        stall, busy, done;
  logic [31:0] result;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  div_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .ALU_sel(alu_sel),
    .op_a   (op_a),
    .op_b   (op_b),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  function automatic logic [31:0] ref_model(input logic [4:0] sel, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (sel)
      C_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      C_REMU:  return (b == 0) ? a : a % b;
      C_DIV:   return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      C_REM:   return (b == 0) ? a : 32'(sa % sb);
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit is_special(input logic [4:0] sel, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 0) || (((sel == C_DIV) || (sel == C_REM)) &&
                        (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge with the unit idle.
  task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input bit b2b, input logic [4:0] nsel,
                        input logic [31:0] na, input logic [31:0] nb);
    logic [31:0] exp_res;
    int          exp_lat, lat, bad_stall;
    bit          seen;
    exp_res = ref_model(sel, a, b);
    exp_lat = is_special(sel, a, b) ? 1 : 33;
    start = 1'b1; alu_sel = sel; op_a = a; op_b = b; flush = 1'b0;
    #1 chk({tag, "/stall_accept"}, {31'b0, stall}, 32'd1);
    lat = 0; seen = 1'b0; bad_stall = 0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      start = 1'b0; op_a = $urandom; op_b = $urandom; alu_sel = 5'($urandom);
      #1;
      if (done) seen = 1'b1;
      else if (!stall) bad_stall++;
    end
    chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/result"}, result, exp_res);
    chk({tag, "/stall_gaps"}, 32'(bad_stall), 32'd0);
    if (seen) begin
      chk({tag, "/stall_done"}, {31'b0, stall}, 32'd0);
      if (b2b) begin
        start = 1'b1; alu_sel = nsel; op_a = na; op_b = nb;
        #1 chk({tag, "/b2b_not_seen"}, {31'b0, stall}, 32'd0);
      end
    end
    @(posedge clk); #1;
    chk({tag, "/done_pulse"}, {31'b0, done}, 32'd0);
    chk({tag, "/busy_idle"}, {31'b0, busy}, 32'd0);
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] prev, ra, rb;
    logic [4:0]  rsel;
    int          dcnt;
    logic [4:0]  sels [4];
    sels[0] = C_DIV; sels[1] = C_DIVU; sels[2] = C_REM; sels[3] = C_REMU;

    rst_n = 1'b0; start = 1'b1; flush = 1'b0; alu_sel = C_DIV; op_a = 32'd100; op_b = 32'd7;
    #2 chk("rst/stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    chk("rst/busy", {31'b0, busy}, 32'd0);
    chk("rst/done", {31'b0, done}, 32'd0);
    chk("rst/result", result, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(C_DIV, 32'd100, 32'd7, "div100_7", 1'b1, C_REM, 32'd100, 32'd7);
    run_op(C_REM, 32'd100, 32'd7, "rem100_7", 1'b0, C_ADD, 32'd0, 32'd0);
    run_op(C_DIV, -32'd7, 32'd2, "div_m7_2", 1'b0, C_ADD, 32'd0, 32'd0);
    run_op(C_REM, -32'd7, 32'd2, "rem_m7_2", 1'b0, C_ADD, 32'd0, 32'd0);
    run_op(C_DIVU, 32'hFFFF_FFF9, 32'd2, "divu_big", 1'b0, C_ADD, 32'd0, 32'd0);
    run_op(C_REMU, 32'hFFFF_FFF9, 32'd2, "remu_big", 1'b0, C_ADD, 32'd0, 32'd0);
    run_op(C_DIVU, 32'd5, 32'd0, "divu_by0", 1'b0, C_ADD, 32'd0, 32'd0);
    run_op(C_REMU, 32'd5, 32'd0, "remu_by0", 1'b0, C_ADD, 32'd0, 32'd0);
    run_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0, C_ADD, 32'd0, 32'd0);
    run_op(C_REM, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 1'b0, C_ADD, 32'd0, 32'd0);

    // Non-divide code must not engage the unit.
    start = 1'b1; alu_sel = C_ADD; op_a = 32'd3; op_b = 32'd4;
    #1 chk("add/stall", {31'b0, stall}, 32'd0);
    dcnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (busy || done) dcnt++;
    end
    chk("add/no_activity", 32'(dcnt), 32'd0);
    start = 1'b0;

    // Flush in CALC cycle 10.
    prev = result;
    start = 1'b1; alu_sel = C_DIV; op_a = 32'd1000; op_b = 32'd3;
    repeat (10) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("flush/busy_before", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    #1 chk("flush/stall", {31'b0, stall}, 32'd0);
    chk("flush/busy", {31'b0, busy}, 32'd0);
    chk("flush/result_kept", result, prev);
    dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("flush/no_done", 32'(dcnt), 32'd0);
    run_op(C_DIVU, 32'd9, 32'd3, "after_flush", 1'b0, C_ADD, 32'd0, 32'd0);

    for (int i = 0; i < 40; i++) begin
      rsel = sels[$urandom_range(0, 3)];
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2, 3:    rb = 32'($urandom_range(1, 300));
        4:       rb = -32'($urandom_range(1, 300));
        default: ;
      endcase
      run_op(rsel, ra, rb, "random", 1'b0, C_ADD, 32'd0, 32'd0);
    end

    // Reset asserted during CALC cycle 20.
    start = 1'b1; alu_sel = C_DIVU; op_a = 32'd77; op_b = 32'd5;
    repeat (20) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    start = 1'b1; alu_sel = C_DIV;
    rst_n = 1'b0;
    #1;
    chk("midrst/stall", {31'b0, stall}, 32'd0);
    chk("midrst/busy", {31'b0, busy}, 32'd0);
    chk("midrst/done", {31'b0, done}, 32'd0);
    chk("midrst/result", result, 32'd0);
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(C_DIVU, 32'd20, 32'd4, "post_reset", 1'b0, C_ADD, 32'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
